// File: rtl/xor_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xor_mem_pkg
// Description : Shared types, constants and lane-slicing helpers for the
//               XOR multiported memory write front-end.
// Revision    : 1.0 - initial release
// ============================================================================
package xor_mem_pkg;

    // Number of write ports on the XOR memory (and request lanes here).
    localparam int NUM_WPORTS = 4;

    // Scheduler state: clear sweep, then normal traffic.
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // LSB position of lane 'lane' inside a flat vector of 'width'-bit lanes.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

    // Next lane in circular order 0..3 (natural 2-bit wrap).
    function automatic logic [1:0] lane_inc(input logic [1:0] lane);
        return lane + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/xor_mem_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : xor_mem_rr_pick
// Description : 4-way circular priority picker. Returns a one-hot grant for
//               the first set request bit at or after i_ptr, scanning
//               i_ptr, i_ptr+1, ... modulo 4. Zero grant if no request.
// Ports       : i_req   [4] request mask
//               i_ptr   [2] starting lane of the circular scan
//               o_grant [4] one-hot winner (or all zero)
// Revision    : 1.0 - initial release
// ============================================================================
module xor_mem_rr_pick
    import xor_mem_pkg::*;
(
    input  logic [NUM_WPORTS-1:0] i_req,
    input  logic [1:0]            i_ptr,
    output logic [NUM_WPORTS-1:0] o_grant
);

    logic [1:0] w_idx;
    logic       w_found;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = i_ptr;
        for (int i = 0; i < NUM_WPORTS; i++) begin
            // 2-bit addition wraps naturally, giving the circular order.
            w_idx = i_ptr + 2'(i);
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/xor_mem_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : xor_mem_write_scheduler
// Description : Front-end for the 4-write-port XOR multiported memory.
//               Accepts up to four writes per cycle on valid/ready lanes,
//               blocks same-address writes within a cycle (round-robin
//               winner) and cross-lane same-address writes in back-to-back
//               cycles, both of which would corrupt XOR bank contents.
//               After reset it optionally sweeps every address through
//               lane 0 with INIT_VALUE.
// Ports       : clk, rst           clock, async active-high reset
//               i_req_valid [4]    per-lane request valid
//               i_req_addr  [4*AW] lane k address at [k*AW +: AW]
//               i_req_data  [4*DW] lane k data at [k*DW +: DW]
//               o_req_ready [4]    per-lane accept (valid & ready = transfer)
//               o_we        [4]    memory write enables, ports 1..4
//               o_wa        [4*AW] memory write addresses
//               o_wd        [4*DW] memory write data
//               o_init_done        clear sweep finished (or skipped)
//               o_conflict_cnt[16] saturating count of hazard-stall cycles
// Revision    : 1.0 - initial release
// ============================================================================
module xor_mem_write_scheduler
    import xor_mem_pkg::*;
#(
    parameter int                    ADDR_WIDTH    = 10,
    parameter int                    DATA_WIDTH    = 32,
    parameter bit                    INIT_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_WPORTS-1:0]            i_req_valid,
    input  logic [NUM_WPORTS*ADDR_WIDTH-1:0] i_req_addr,
    input  logic [NUM_WPORTS*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_WPORTS-1:0]            o_req_ready,
    output logic [NUM_WPORTS-1:0]            o_we,
    output logic [NUM_WPORTS*ADDR_WIDTH-1:0] o_wa,
    output logic [NUM_WPORTS*DATA_WIDTH-1:0] o_wd,
    output logic                             o_init_done,
    output logic [15:0]                      o_conflict_cnt
);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t                                  r_state;
    logic [ADDR_WIDTH-1:0]                   r_init_cnt;
    logic [1:0]                              r_rr_ptr;
    logic [NUM_WPORTS-1:0]                   r_we;
    logic [NUM_WPORTS-1:0][ADDR_WIDTH-1:0]   r_wa;
    logic [NUM_WPORTS-1:0][DATA_WIDTH-1:0]   r_wd;
    logic                                    r_init_done;
    logic [15:0]                             r_conflict_cnt;

    // ------------------------------------------------------------------
    // Combinational grant logic
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0]                   w_addr  [NUM_WPORTS];
    logic [DATA_WIDTH-1:0]                   w_data  [NUM_WPORTS];
    logic [NUM_WPORTS-1:0]                   w_mask  [NUM_WPORTS];
    logic [NUM_WPORTS-1:0]                   w_grant [NUM_WPORTS];
    logic [NUM_WPORTS-1:0]                   w_blk;
    logic [NUM_WPORTS-1:0]                   w_ready;
    logic [NUM_WPORTS-1:0]                   w_coll;
    logic [NUM_WPORTS-1:0]                   w_win_oh;
    logic [NUM_WPORTS-1:0]                   w_accept;
    logic [1:0]                              w_win_idx;
    logic                                    w_fire;
    logic                                    w_stall;
    logic                                    w_run;

    assign w_run = (r_state == ST_RUN);

    // Back-to-back hazard: another lane wrote this lane's address on the
    // previous edge. A lane repeating its own address is harmless because
    // it lands in the same bank column.
    // Collision group of lane k: every unblocked lane with the same address
    // that is either lane k itself or actually requesting. Including k
    // unconditionally keeps ready independent of k's own valid, while only
    // valid peers can take the grant away from k.
    always_comb begin
        w_blk = '0;
        for (int k = 0; k < NUM_WPORTS; k++) begin
            for (int j = 0; j < NUM_WPORTS; j++) begin
                if ((j != k) && r_we[j] && (r_wa[j] == w_addr[k])) begin
                    w_blk[k] = 1'b1;
                end
            end
        end
        for (int k = 0; k < NUM_WPORTS; k++) begin
            for (int j = 0; j < NUM_WPORTS; j++) begin
                w_mask[k][j] = !w_blk[j] && (w_addr[j] == w_addr[k]) &&
                               ((j == k) || i_req_valid[j]);
            end
        end
    end

    for (genvar k = 0; k < NUM_WPORTS; k++) begin : g_lane
        assign w_addr[k] = i_req_addr[lane_lsb(k, ADDR_WIDTH) +: ADDR_WIDTH];
        assign w_data[k] = i_req_data[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH];

        xor_mem_rr_pick u_pick (
            .i_req   (w_mask[k]),
            .i_ptr   (r_rr_ptr),
            .o_grant (w_grant[k])
        );

        assign w_ready[k] = w_run && !w_blk[k] && w_grant[k][k];
    end

    // A lane is a collision winner when it is accepted while at least one
    // other valid lane shares its address. If several groups collide in the
    // same cycle, the pointer follows the first winner in circular order.
    always_comb begin
        w_coll = '0;
        for (int k = 0; k < NUM_WPORTS; k++) begin
            w_coll[k] = i_req_valid[k] && w_ready[k] &&
                        (|(w_mask[k] & (w_mask[k] - 4'd1)));
        end
    end

    xor_mem_rr_pick u_win (
        .i_req   (w_coll),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_win_oh)
    );

    always_comb begin
        w_win_idx = '0;
        for (int k = 0; k < NUM_WPORTS; k++) begin
            if (w_win_oh[k]) begin
                w_win_idx = 2'(k);
            end
        end
        w_fire   = |w_coll;
        w_accept = i_req_valid & w_ready;
        w_stall  = w_run && (|(i_req_valid & ~w_ready));
    end

    // ------------------------------------------------------------------
    // State machine and registered memory-port drive
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= INIT_ON_RESET ? ST_INIT : ST_RUN;
            r_init_cnt     <= '0;
            r_rr_ptr       <= '0;
            r_we           <= '0;
            r_wa           <= '0;
            r_wd           <= '0;
            r_init_done    <= !INIT_ON_RESET;
            r_conflict_cnt <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_we       <= {{(NUM_WPORTS-1){1'b0}}, 1'b1};
                    r_wa[0]    <= r_init_cnt;
                    r_wd[0]    <= INIT_VALUE;
                    r_init_cnt <= r_init_cnt + ADDR_WIDTH'(1);
                    if (&r_init_cnt) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Set on the first RUN edge, so it rises one cycle after
                    // the last sweep write is driven.
                    r_init_done <= 1'b1;
                    r_we        <= w_accept;
                    for (int k = 0; k < NUM_WPORTS; k++) begin
                        if (w_accept[k]) begin
                            r_wa[k] <= w_addr[k];
                            r_wd[k] <= w_data[k];
                        end
                    end
                    if (w_fire) begin
                        r_rr_ptr <= lane_inc(w_win_idx);
                    end
                    if (w_stall && (r_conflict_cnt != 16'hFFFF)) begin
                        r_conflict_cnt <= r_conflict_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign o_req_ready    = w_ready;
    assign o_we           = r_we;
    assign o_wa           = r_wa;
    assign o_wd           = r_wd;
    assign o_init_done    = r_init_done;
    assign o_conflict_cnt = r_conflict_cnt;

endmodule
`default_nettype wire

// File: tb/tb_xor_mem_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_xor_mem_write_scheduler
// Description : Scoreboard bench for xor_mem_write_scheduler. A requester
//               model holds each lane's request until accepted; a reference
//               model applies the grant rules and pushes expected memory
//               writes into a queue that a separate monitor drains.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xor_mem_write_scheduler;

    localparam int             AW       = 4;
    localparam int             DW       = 32;
    localparam int             NL       = 4;
    localparam int             DEPTH    = 1 << AW;
    localparam logic [DW-1:0]  INIT_VAL = 32'hA5A5_0F0F;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NL-1:0]     i_req_valid = '0;
    logic [NL*AW-1:0]  i_req_addr  = '0;
    logic [NL*DW-1:0]  i_req_data  = '0;
    logic [NL-1:0]     o_req_ready;
    logic [NL-1:0]     o_we;
    logic [NL*AW-1:0]  o_wa;
    logic [NL*DW-1:0]  o_wd;
    logic              o_init_done;
    logic [15:0]       o_conflict_cnt;

    xor_mem_write_scheduler #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .INIT_ON_RESET (1'b1),
        .INIT_VALUE    (INIT_VAL)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_req_valid    (i_req_valid),
        .i_req_addr     (i_req_addr),
        .i_req_data     (i_req_data),
        .o_req_ready    (o_req_ready),
        .o_we           (o_we),
        .o_wa           (o_wa),
        .o_wd           (o_wd),
        .o_init_done    (o_init_done),
        .o_conflict_cnt (o_conflict_cnt)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    typedef struct {
        int             lane;
        logic [AW-1:0]  a;
        logic [DW-1:0]  d;
    } wr_t;

    wr_t exp_q[$];
    int  n_vec = 0;
    int  n_bad = 0;

    // Requester: one outstanding request per lane, held until accepted.
    logic [NL-1:0] pend_v;
    logic [AW-1:0] pend_a [NL];
    logic [DW-1:0] pend_d [NL];

    // Reference model state.
    int            init_left;
    logic [AW-1:0] init_addr;
    logic          m_done;
    logic [1:0]    m_rr;
    int            exp_cnt;
    logic [NL-1:0] prev_we;          // lanes that wrote memory last cycle
    logic [AW-1:0] prev_wa [NL];
    logic [NL-1:0] last_rdy;

    // Directed-test scratch.
    int            acc_at [NL];
    logic [NL-1:0] pv;
    int            t_cyc;
    logic [15:0]   cnt0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        init_left = DEPTH;
        init_addr = '0;
        m_done    = 1'b0;
        m_rr      = 2'd0;
        exp_cnt   = 0;
        prev_we   = '0;
        pend_v    = '0;
        for (int k = 0; k < NL; k++) begin
            prev_wa[k] = '0;
            pend_a[k]  = '0;
            pend_d[k]  = '0;
        end
        exp_q.delete();
    endtask

    task automatic set_req(input int k, input int a);
        pend_v[k] = 1'b1;
        pend_a[k] = AW'(a);
        pend_d[k] = $urandom;
    endtask

    task automatic rand_fill();
        for (int k = 0; k < NL; k++) begin
            if (!pend_v[k] && ($urandom_range(0, 9) < 7)) begin
                set_req(k, int'($urandom_range(0, 5)));
            end
        end
    endtask

    // One clock of stimulus, entered and left at a falling edge.
    task automatic run_cycle();
        logic [NL-1:0] v, blk, rdy, acc;
        bit            in_init;
        int            first, j, peers, win;
        v = pend_v;
        for (int k = 0; k < NL; k++) begin
            i_req_addr[k*AW +: AW] = pend_a[k];
            i_req_data[k*DW +: DW] = pend_d[k];
        end
        i_req_valid = v;
        #1;
        chk("init_done", o_init_done, m_done);
        chk("conflict_cnt", o_conflict_cnt, exp_cnt);
        in_init = (init_left > 0);

        // Cross-lane write to the same address on the previous cycle.
        blk = '0;
        for (int k = 0; k < NL; k++)
            for (int jj = 0; jj < NL; jj++)
                if (jj != k && prev_we[jj] && prev_wa[jj] == pend_a[k]) blk[k] = 1'b1;

        // Among unblocked contenders for an address, the first one found
        // walking circularly from the round-robin pointer gets the grant.
        rdy = '0;
        if (!in_init) begin
            for (int k = 0; k < NL; k++) begin
                if (!blk[k]) begin
                    first = -1;
                    for (int off = 0; off < NL; off++) begin
                        j = (int'(m_rr) + off) % NL;
                        if (first < 0 && !blk[j] && pend_a[j] == pend_a[k] && (j == k || v[j]))
                            first = j;
                    end
                    rdy[k] = (first == k);
                end
            end
        end
        chk("ready", o_req_ready, rdy);
        last_rdy = o_req_ready;
        acc = v & rdy;

        if (in_init) begin
            exp_q.push_back('{lane: 0, a: init_addr, d: INIT_VAL});
            prev_wa[0] = init_addr;
            init_addr  = init_addr + AW'(1);
            init_left--;
            prev_we = (init_left == 0) ? 4'b0001 : 4'b0000;
        end else begin
            win = -1;
            for (int off = 0; off < NL; off++) begin
                j = (int'(m_rr) + off) % NL;
                if (win < 0 && acc[j]) begin
                    peers = 0;
                    for (int i = 0; i < NL; i++)
                        if (v[i] && !blk[i] && pend_a[i] == pend_a[j]) peers++;
                    if (peers >= 2) win = j;
                end
            end
            if (win >= 0) m_rr = 2'((win + 1) % NL);
            if ((v & ~rdy) != '0 && exp_cnt < 65535) exp_cnt++;
            for (int k = 0; k < NL; k++) begin
                if (acc[k]) begin
                    exp_q.push_back('{lane: k, a: pend_a[k], d: pend_d[k]});
                    prev_wa[k] = pend_a[k];
                    pend_v[k]  = 1'b0;
                end
            end
            prev_we = acc;
            m_done  = 1'b1;
        end
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Monitor: after each rising edge, everything queued is due now.
    // ------------------------------------------------------------------
    initial begin
        logic [NL-1:0] exp_we;
        wr_t           e;
        forever begin
            @(posedge clk);
            #1;
            exp_we = '0;
            foreach (exp_q[i]) exp_we[exp_q[i].lane] = 1'b1;
            chk("we", o_we, exp_we);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk($sformatf("wa_lane%0d", e.lane), o_wa[e.lane*AW +: AW], e.a);
                chk($sformatf("wd_lane%0d", e.lane), o_wd[e.lane*DW +: DW], e.d);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        model_reset();
        #1;
        chk("rst_we", o_we, 0);
        chk("rst_wa", o_wa, 0);
        chk("rst_wd", o_wd, 0);
        chk("rst_ready", o_req_ready, 0);
        chk("rst_done", o_init_done, 0);
        chk("rst_cnt", o_conflict_cnt, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Full clear sweep with no traffic, plus one cycle past it.
        repeat (DEPTH + 2) run_cycle();

        // Four distinct addresses: full throughput.
        for (int k = 0; k < NL; k++) set_req(k, k + 1);
        run_cycle();
        chk("t1_ready", last_rdy, 4'b1111);
        run_cycle();

        // All lanes to address 5: grants every other cycle, lanes 0..3.
        for (int k = 0; k < NL; k++) begin
            set_req(k, 5);
            acc_at[k] = -1;
        end
        for (int c = 1; c <= 20 && pend_v != '0; c++) begin
            pv = pend_v;
            run_cycle();
            for (int k = 0; k < NL; k++) if (pv[k] && !pend_v[k]) acc_at[k] = c;
        end
        for (int k = 0; k < NL; k++)
            chk($sformatf("t2_grant_cycle_lane%0d", k), acc_at[k], 1 + 2 * k);
        run_cycle();

        // Lane 0 then lane 2 to address 7: lane 2 stalls one cycle.
        set_req(0, 7);
        run_cycle();
        set_req(2, 7);
        cnt0  = o_conflict_cnt;
        t_cyc = 0;
        for (int c = 1; c <= 5 && pend_v[2]; c++) begin
            run_cycle();
            t_cyc = c;
        end
        chk("t3_lane2_accept_cycle", t_cyc, 2);
        chk("t3_conflict_delta", o_conflict_cnt - cnt0, 1);

        // Same-lane repeat to address 9 is never stalled.
        set_req(1, 9);
        run_cycle();
        chk("t4_ready_first", last_rdy[1], 1);
        set_req(1, 9);
        run_cycle();
        chk("t4_ready_second", last_rdy[1], 1);
        run_cycle();

        // Reset in the middle of a sweep.
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) run_cycle();
        #2 rst = 1'b1;
        #1;
        chk("midrst_we", o_we, 0);
        chk("midrst_wa", o_wa, 0);
        chk("midrst_wd", o_wd, 0);
        chk("midrst_done", o_init_done, 0);
        chk("midrst_ready", o_req_ready, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Restarted sweep with requests already pending, then random traffic.
        for (int c = 0; c < 400; c++) begin
            rand_fill();
            run_cycle();
        end

        // Drain: every held request must eventually be accepted.
        for (int c = 0; c < 60 && pend_v != '0; c++) run_cycle();
        n_vec++;
        if (pend_v != '0) begin
            n_bad++;
            $display("FAIL drain: got pending %b, want 0000", pend_v);
        end
        run_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
